// File: rtl/multi_rate_enable_pkg.sv
// Shared types and helpers for the multi-rate clock-enable generator.
package multi_rate_enable_pkg;

    typedef enum logic {
        MODE_INT  = 1'b0,
        MODE_FRAC = 1'b1
    } mode_e;

    localparam int              DEF_ACC_W = 32;
    localparam longint unsigned DEF_DIV   = 64'd31250;

    // Channel-select width; a single-channel bank still needs a 1-bit select.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Layout at the default width; channels re-declare it at their own ACC_W.
    typedef struct packed {
        mode_e                mode;
        logic [DEF_ACC_W-1:0] val;
    } ch_cfg_t;

endpackage

// File: rtl/multi_rate_enable_gen_channel.sv
// One enable channel: integer divider or NCO accumulator with a shadow
// config register that is swapped in only at a period boundary.
module enable_channel
    import multi_rate_enable_pkg::*;
#(
    parameter int              ACC_W       = DEF_ACC_W,
    parameter longint unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  mode_e            wr_mode,
    input  logic [ACC_W-1:0] wr_val,
    input  logic             sync,
    output logic             en,
    output logic             pend
);

    typedef struct packed {
        mode_e            mode;
        logic [ACC_W-1:0] val;
    } cfg_t;

    localparam logic [ACC_W-1:0] RESET_VAL = ACC_W'(DEFAULT_DIV);

    cfg_t             active;
    cfg_t             shadow;
    cfg_t             new_cfg;
    logic [ACC_W-1:0] cnt;
    logic [ACC_W:0]   sum;
    logic             disabled;
    logic             wrap;
    logic             apply;

    always_comb begin
        new_cfg.mode = wr_mode;
        new_cfg.val  = wr_val;
        sum          = {1'b0, cnt} + {1'b0, active.val};
        disabled     = (active.val == '0);
        if (active.mode == MODE_FRAC) begin
            wrap = sum[ACC_W];
        end else begin
            wrap = !disabled && (cnt == active.val - ACC_W'(1));
        end
        // pend is the registered value, so a write landing on a wrap waits a period
        apply = pend && (wrap || disabled);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active.mode <= MODE_INT;
            active.val  <= RESET_VAL;
            shadow.mode <= MODE_INT;
            shadow.val  <= RESET_VAL;
            cnt         <= '0;
            pend        <= 1'b0;
            en          <= 1'b0;
        end else if (sync) begin
            en   <= 1'b0;
            cnt  <= '0;
            pend <= 1'b0;
            if (wr) begin
                active <= new_cfg;
                shadow <= new_cfg;
            end else if (pend) begin
                active <= shadow;
            end
        end else begin
            en <= wrap;
            if (apply) begin
                active <= shadow;
                cnt    <= '0;
                pend   <= 1'b0;
            end else if (active.mode == MODE_FRAC) begin
                cnt <= sum[ACC_W-1:0];
            end else if (wrap || disabled) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ACC_W'(1);
            end
            if (wr) begin
                shadow <= new_cfg;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_rate_enable_gen.sv
// Bank of independent clock-enable channels with a shared valid/ready
// config port and a global phase-align request.
module multi_rate_enable_gen
    import multi_rate_enable_pkg::*;
#(
    parameter int              NUM_CH      = 4,
    parameter int              ACC_W       = DEF_ACC_W,
    parameter longint unsigned DEFAULT_DIV = DEF_DIV,
    localparam int             CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_mode,
    input  logic [ACC_W-1:0]  cfg_val,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] ch_pend
);

    logic [NUM_CH-1:0] sel;
    logic              pend_sel;
    logic              in_range;
    logic              accept;

    always_comb begin
        sel      = '0;
        pend_sel = 1'b0;
        in_range = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                sel[i]   = 1'b1;
                pend_sel = ch_pend[i];
                in_range = 1'b1;
            end
        end
    end

    // Out-of-range writes are acknowledged and dropped so a bad address cannot stall the master.
    assign cfg_ready = rst_n & (in_range ? ~pend_sel : 1'b1);
    assign accept    = cfg_valid & cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        enable_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (accept & sel[g]),
            .wr_mode (mode_e'(cfg_mode)),
            .wr_val  (cfg_val),
            .sync    (sync_req),
            .en      (ch_en[g]),
            .pend    (ch_pend[g])
        );
    end

endmodule
